// File: rtl/store_unit.sv
// store_unit: aligns a byte/halfword/word store onto a 32-bit memory write port with legality checks and timeout
module store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [1:0]  req_size,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   state_t state, state_nx;
   logic [31:0] addr_q, data_q;
   logic [1:0] size_q, code;
   logic [CW-1:0] cnt;
   logic to_q, accept, last;
   function automatic logic [1:0] legality(input logic [1:0] a, input logic [1:0] s);
      return s == 2'b11 ? 2'b10 :
             ((s == 2'b01 && a[0]) || (s == 2'b10 && a != 2'b00)) ? 2'b01 : 2'b00;
   endfunction
   assign accept = req_valid && state == IDLE;
   assign last = cnt == CW'(TIMEOUT - 1);
   // state register, captured request fields and the per-visit ISSUE cycle counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         addr_q <= '0;
         data_q <= '0;
         size_q <= '0;
         to_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= state == ISSUE ? cnt + CW'(1) : '0;
         if (accept) begin
            addr_q <= req_addr;
            data_q <= req_data;
            size_q <= req_size;
            to_q <= 1'b0;
         end
         if (state == ISSUE) to_q <= !mem_ready && last;
      end
   end
   // next state and all outputs; payload is zero whenever no write is offered
   always_comb begin
      state_nx = state;
      if (accept) state_nx = legality(req_addr[1:0], req_size) != 2'b00 ? RESP : ISSUE;
      else if (state == ISSUE && (mem_ready || last)) state_nx = RESP;
      else if (state == RESP) state_nx = IDLE;
      code = to_q ? 2'b11 : legality(addr_q[1:0], size_q);
      req_ready = state == IDLE;
      mem_valid = state == ISSUE;
      mem_addr = mem_valid ? {addr_q[31:2], 2'b00} : 32'h0;
      mem_be = !mem_valid ? 4'b0000 :
               size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
               size_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      mem_wdata = !mem_valid ? 32'h0 :
                  size_q == 2'b00 ? {4{data_q[7:0]}} :
                  size_q == 2'b01 ? {2{data_q[15:0]}} : data_q;
      done = state == RESP && code == 2'b00;
      err = state == RESP && code != 2'b00;
      err_code = state == RESP ? code : 2'b00;
   end
endmodule
